store_checker: RTL
==================

# store_checker

Synthesizable end-of-test checker that sits directly downstream of the pipelined core's data-memory store port (MemWrite/DataAdr/WriteData). It classifies every store, latches a sticky pass/fail/timeout verdict, and captures the core's checksum register and diagnostic counters. This lets an FPGA build or a bench report a verdict without hierarchical peeking.

## Interface

Parameters:
- PASS_ADDR, 100: byte address whose store ends the test.
- PASS_DATA, 25: value required at PASS_ADDR for a pass.
- SCRATCH_ADDR, 96: address of stores that are legal and non-terminating.
- TIMEOUT_CYCLES, 10000: RUN-state cycle budget; must be ≥ 2.
- CW, 32: width of cycle_count.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; same signal that resets the core.
- MemWrite  in  1  store strobe from the core's MEM stage.
- DataAdr  in  32  store byte address.
- WriteData  in  32  store data.
- Checksum  in  32  live value of core register x28.
- done  out  1  verdict reached (state ≠ RUN).
- pass  out  1  terminated by a correct store to PASS_ADDR.
- fail  out  1  terminated by an illegal or wrong store.
- timeout  out  1  budget exhausted with no terminating store.
- store_count  out  16  number of stores accepted in RUN.
- cycle_count  out  CW  rising edges spent in RUN.
- fail_addr  out  32  DataAdr of the failing store.
- fail_data  out  32  WriteData of the failing store.
- checksum_q  out  32  Checksum sampled on the terminating edge.

## Operation

- FSM states: RUN, PASS, FAIL, TIMEOUT. Reset enters RUN.
- A store event is a rising edge with MemWrite=1 while in RUN. Edges in other states ignore MemWrite.
- On a store event, in priority order:
  - DataAdr==PASS_ADDR && WriteData==PASS_DATA → PASS.
  - DataAdr==PASS_ADDR with any other data → FAIL.
  - DataAdr==SCRATCH_ADDR → stay in RUN.
  - Any other address → FAIL.
- Comparisons are exact 32-bit equality. No masking, no byte-lane decode.
- store_count increments on every store event, including the terminating one. It saturates at 16'hFFFF.
- cycle_count increments on every rising edge taken in RUN, including the terminating edge. It is frozen in terminal states.
- Timeout: on an edge in RUN with cycle_count==TIMEOUT_CYCLES-1 and no store event → TIMEOUT. cycle_count becomes TIMEOUT_CYCLES.
- A store event and the timeout condition on the same edge: the store wins. It is classified normally; if it is a scratch store, state remains RUN and the next edge times out.
- fail_addr and fail_data load only on the transition into FAIL.
- checksum_q loads on any transition into PASS, FAIL or TIMEOUT.
- Terminal states are sticky until reset.
- Outputs are decoded from registered state only. There are no combinational paths from inputs to outputs.

## Timing

- Reset values: state RUN; done, pass, fail, timeout all 0; store_count 0; cycle_count 0; fail_addr 0; fail_data 0; checksum_q 0.
- Latency:
  - A store sampled at edge k shows its verdict and counter update after edge k, i.e. visible throughout cycle k+1.
  - A bench sampling at negedge k sees the pre-update values.
- Exactly one of pass/fail/timeout is 1 whenever done=1. All are 0 when done=0.
- Reset asserted mid-run or in a terminal state returns all state to reset values at the next edge. MemWrite on that same edge is ignored.
- After reset deasserts, the first counted edge is the first edge with reset=0.
- MemWrite held high for N consecutive edges counts as N stores.

## Test plan

- Reset 2 edges, then stores (96, 7), (96, 9), (100, 25) on consecutive edges with Checksum=0x1234 → after 3rd edge: pass=1, done=1, store_count=3, cycle_count=3, checksum_q=0x00001234.
- Stores (96, 1), (104, 0xDEAD) → fail=1, fail_addr=104, fail_data=0x0000DEAD, store_count=2; a later (100, 25) leaves fail=1 and store_count=2.
- Store (100, 24) → fail=1, fail_addr=100, fail_data=24.
- TIMEOUT_CYCLES=8, no stores → timeout=1 after the 8th edge, cycle_count=8, stays 8 for 20 more edges. Repeat with (96, x) on edge 8 → still RUN after edge 8, timeout=1 after edge 9.
- Reach PASS, assert reset 1 edge with MemWrite=1 (100, 25) → all outputs return to reset values. Rerun to PASS with identical counts.
- TIMEOUT_CYCLES=8, store (100, 25) exactly on edge 8 → pass=1, timeout=0, cycle_count=8.

Source files
------------

// File: rtl/store_checker.sv
// End-of-test checker on the core's data-memory store port: classifies each store,
// latches a sticky pass/fail/timeout verdict and snapshots the checksum and counters.
module store_checker #(
    parameter logic [31:0] PASS_ADDR      = 32'd100,
    parameter logic [31:0] PASS_DATA      = 32'd25,
    parameter logic [31:0] SCRATCH_ADDR   = 32'd96,
    parameter int          TIMEOUT_CYCLES = 10000,
    parameter int          CW             = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemWrite,
    input  logic [31:0]   DataAdr,
    input  logic [31:0]   WriteData,
    input  logic [31:0]   Checksum,
    output logic          done,
    output logic          pass,
    output logic          fail,
    output logic          timeout,
    output logic [15:0]   store_count,
    output logic [CW-1:0] cycle_count,
    output logic [31:0]   fail_addr,
    output logic [31:0]   fail_data,
    output logic [31:0]   checksum_q
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PASS    = 2'd1,
        FAIL    = 2'd2,
        TIMEOUT = 2'd3
    } state_t;

    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t        state_q;
    logic [15:0]   store_count_q;
    logic [CW-1:0] cycle_count_q;
    logic [31:0]   fail_addr_q;
    logic [31:0]   fail_data_q;
    logic [31:0]   checksum_qq;

    // A scratch store on the last budgeted edge pushes the count past the limit,
    // so the timeout test uses >= to fire on the following idle edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            store_count_q <= '0;
            cycle_count_q <= '0;
            fail_addr_q   <= '0;
            fail_data_q   <= '0;
            checksum_qq   <= '0;
        end else if (state_q == RUN) begin
            cycle_count_q <= cycle_count_q + 1'b1;
            if (MemWrite) begin
                if (store_count_q != 16'hFFFF) begin
                    store_count_q <= store_count_q + 16'd1;
                end
                if (DataAdr == PASS_ADDR && WriteData == PASS_DATA) begin
                    state_q     <= PASS;
                    checksum_qq <= Checksum;
                end else if (DataAdr != SCRATCH_ADDR) begin
                    state_q     <= FAIL;
                    fail_addr_q <= DataAdr;
                    fail_data_q <= WriteData;
                    checksum_qq <= Checksum;
                end
            end else if (cycle_count_q >= TIMEOUT_LAST) begin
                state_q     <= TIMEOUT;
                checksum_qq <= Checksum;
            end
        end
    end

    assign done        = (state_q != RUN);
    assign pass        = (state_q == PASS);
    assign fail        = (state_q == FAIL);
    assign timeout     = (state_q == TIMEOUT);
    assign store_count = store_count_q;
    assign cycle_count = cycle_count_q;
    assign fail_addr   = fail_addr_q;
    assign fail_data   = fail_data_q;
    assign checksum_q  = checksum_qq;

endmodule
